// File: rtl/multicycle_control.sv
// Multicycle MIPS main control: Moore FSM sequencing fetch/decode/execute/memory/writeback,
// with a memory-ready handshake, optional addi, illegal-opcode detection and a retire counter.
module multicycle_control #(
   parameter int CNT_W         = 16,
   parameter bit HAS_ADDI      = 1'b1,
   parameter bit MEM_HANDSHAKE = 1'b1
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [5:0]       Op,
   input  logic             MemReady,
   output logic             PCWrite,
   output logic             PCWriteCond,
   output logic             IorD,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             MemtoReg,
   output logic             IRWrite,
   output logic             ALUSrcA,
   output logic             RegWrite,
   output logic             RegDst,
   output logic [1:0]       ALUOp,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       PCSource,
   output logic             IllegalOp,
   output logic [3:0]       State,
   output logic [CNT_W-1:0] InstrCount
);

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_RCOMP  = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_ADDIEX = 4'd10,
      S_ADDIWB = 4'd11
   } state_t;

   state_t state, state_next;
   logic   is_sw;
   logic   mem_rdy;
   logic   retire;

   assign mem_rdy = MEM_HANDSHAKE ? MemReady : 1'b1;
   assign State   = state;

   // Op is only valid in DECODE, so the lw/sw split taken in MEMADR uses a copy captured there.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state      <= S_FETCH;
         is_sw      <= 1'b0;
         InstrCount <= '0;
      end else begin
         state <= state_next;
         if (state == S_DECODE)
            is_sw <= (Op == OP_SW);
         if (retire)
            InstrCount <= InstrCount + CNT_W'(1);
      end
   end

   always_comb begin
      state_next  = state;
      retire      = 1'b0;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      MemtoReg    = 1'b0;
      IRWrite     = 1'b0;
      ALUSrcA     = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      ALUOp       = 2'b00;
      ALUSrcB     = 2'b00;
      PCSource    = 2'b00;
      IllegalOp   = 1'b0;
      // While Reset is high every output stays at its zero default.
      if (!Reset) begin
         case (state)
            S_FETCH: begin
               MemRead = 1'b1;
               ALUSrcB = 2'b01;
               IRWrite = mem_rdy;
               PCWrite = mem_rdy;
               if (mem_rdy) state_next = S_DECODE;
            end
            S_DECODE: begin
               ALUSrcB = 2'b11;
               case (Op)
                  OP_LW, OP_SW: state_next = S_MEMADR;
                  OP_R:         state_next = S_EXEC;
                  OP_BEQ:       state_next = S_BRANCH;
                  OP_J:         state_next = S_JUMP;
                  OP_ADDI: begin
                     if (HAS_ADDI) begin
                        state_next = S_ADDIEX;
                     end else begin
                        state_next = S_FETCH;
                        IllegalOp  = 1'b1;
                     end
                  end
                  default: begin
                     state_next = S_FETCH;
                     IllegalOp  = 1'b1;
                  end
               endcase
            end
            S_MEMADR: begin
               ALUSrcA    = 1'b1;
               ALUSrcB    = 2'b10;
               state_next = is_sw ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
               MemRead = 1'b1;
               IorD    = 1'b1;
               if (mem_rdy) state_next = S_MEMWB;
            end
            S_MEMWB: begin
               RegWrite   = 1'b1;
               MemtoReg   = 1'b1;
               retire     = 1'b1;
               state_next = S_FETCH;
            end
            S_MEMWR: begin
               MemWrite = 1'b1;
               IorD     = 1'b1;
               if (mem_rdy) begin
                  retire     = 1'b1;
                  state_next = S_FETCH;
               end
            end
            S_EXEC: begin
               ALUSrcA    = 1'b1;
               ALUOp      = 2'b10;
               state_next = S_RCOMP;
            end
            S_RCOMP: begin
               RegWrite   = 1'b1;
               RegDst     = 1'b1;
               retire     = 1'b1;
               state_next = S_FETCH;
            end
            S_BRANCH: begin
               ALUSrcA     = 1'b1;
               ALUOp       = 2'b01;
               PCWriteCond = 1'b1;
               PCSource    = 2'b01;
               retire      = 1'b1;
               state_next  = S_FETCH;
            end
            S_JUMP: begin
               PCWrite    = 1'b1;
               PCSource   = 2'b10;
               retire     = 1'b1;
               state_next = S_FETCH;
            end
            S_ADDIEX: begin
               ALUSrcA    = 1'b1;
               ALUSrcB    = 2'b10;
               state_next = S_ADDIWB;
            end
            S_ADDIWB: begin
               RegWrite   = 1'b1;
               retire     = 1'b1;
               state_next = S_FETCH;
            end
            default: state_next = S_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a default-parameter instance driven from a vector
// table, and a CNT_W=4 / no-addi / no-handshake instance driven by hand-written sequences.
module tb_multicycle_control;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_BAD  = 6'b111111;

   // Control vector bit positions: {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
   // IRWrite, ALUSrcA, RegWrite, RegDst, ALUOp[1:0], ALUSrcB[1:0], PCSource[1:0], IllegalOp}
   localparam logic [16:0] C_PCW    = 17'h10000;
   localparam logic [16:0] C_PCWC   = 17'h08000;
   localparam logic [16:0] C_IORD   = 17'h04000;
   localparam logic [16:0] C_MR     = 17'h02000;
   localparam logic [16:0] C_MW     = 17'h01000;
   localparam logic [16:0] C_M2R    = 17'h00800;
   localparam logic [16:0] C_IRW    = 17'h00400;
   localparam logic [16:0] C_SRCA   = 17'h00200;
   localparam logic [16:0] C_RW     = 17'h00100;
   localparam logic [16:0] C_RDST   = 17'h00080;
   localparam logic [16:0] C_OP_FN  = 17'h00040;
   localparam logic [16:0] C_OP_SUB = 17'h00020;
   localparam logic [16:0] C_SB_IMM = 17'h00010;
   localparam logic [16:0] C_SB_4   = 17'h00008;
   localparam logic [16:0] C_SB_SH  = 17'h00018;
   localparam logic [16:0] C_PS_JMP = 17'h00004;
   localparam logic [16:0] C_PS_OUT = 17'h00002;
   localparam logic [16:0] C_ILL    = 17'h00001;

   localparam logic [16:0] E_FETCH   = C_MR | C_SB_4 | C_IRW | C_PCW;
   localparam logic [16:0] E_FETCH_W = C_MR | C_SB_4;
   localparam logic [16:0] E_DEC     = C_SB_SH;
   localparam logic [16:0] E_DEC_ILL = C_SB_SH | C_ILL;
   localparam logic [16:0] E_MADR    = C_SRCA | C_SB_IMM;
   localparam logic [16:0] E_MRD     = C_MR | C_IORD;
   localparam logic [16:0] E_MWB     = C_RW | C_M2R;
   localparam logic [16:0] E_MWR     = C_MW | C_IORD;
   localparam logic [16:0] E_EXEC    = C_SRCA | C_OP_FN;
   localparam logic [16:0] E_RC      = C_RW | C_RDST;
   localparam logic [16:0] E_BR      = C_SRCA | C_OP_SUB | C_PCWC | C_PS_OUT;
   localparam logic [16:0] E_J       = C_PCW | C_PS_JMP;
   localparam logic [16:0] E_AEX     = C_SRCA | C_SB_IMM;
   localparam logic [16:0] E_AWB     = C_RW;

   // clock / reset
   logic Clk = 1'b0;
   always #5 Clk = ~Clk;

   // instance 1: defaults
   logic        Reset, MemReady;
   logic [5:0]  Op;
   logic        pcw1, pcwc1, iord1, mr1, mw1, m2r1, irw1, srca1, rw1, rdst1, ill1;
   logic [1:0]  aluop1, srcb1, pcsrc1;
   logic [3:0]  st1;
   logic [15:0] cnt1;
   logic [16:0] ctrl1;

   multicycle_control dut (
      .Clk(Clk), .Reset(Reset), .Op(Op), .MemReady(MemReady),
      .PCWrite(pcw1), .PCWriteCond(pcwc1), .IorD(iord1), .MemRead(mr1), .MemWrite(mw1),
      .MemtoReg(m2r1), .IRWrite(irw1), .ALUSrcA(srca1), .RegWrite(rw1), .RegDst(rdst1),
      .ALUOp(aluop1), .ALUSrcB(srcb1), .PCSource(pcsrc1), .IllegalOp(ill1),
      .State(st1), .InstrCount(cnt1)
   );
   assign ctrl1 = {pcw1, pcwc1, iord1, mr1, mw1, m2r1, irw1, srca1, rw1, rdst1,
                   aluop1, srcb1, pcsrc1, ill1};

   // instance 2: small counter, no addi, no handshake
   logic        rst2, rdy2;
   logic [5:0]  op2;
   logic        pcw2, pcwc2, iord2, mr2, mw2, m2r2, irw2, srca2, rw2, rdst2, ill2;
   logic [1:0]  aluop2, srcb2, pcsrc2;
   logic [3:0]  st2;
   logic [3:0]  cnt2;
   logic [16:0] ctrl2;

   multicycle_control #(.CNT_W(4), .HAS_ADDI(1'b0), .MEM_HANDSHAKE(1'b0)) dut2 (
      .Clk(Clk), .Reset(rst2), .Op(op2), .MemReady(rdy2),
      .PCWrite(pcw2), .PCWriteCond(pcwc2), .IorD(iord2), .MemRead(mr2), .MemWrite(mw2),
      .MemtoReg(m2r2), .IRWrite(irw2), .ALUSrcA(srca2), .RegWrite(rw2), .RegDst(rdst2),
      .ALUOp(aluop2), .ALUSrcB(srcb2), .PCSource(pcsrc2), .IllegalOp(ill2),
      .State(st2), .InstrCount(cnt2)
   );
   assign ctrl2 = {pcw2, pcwc2, iord2, mr2, mw2, m2r2, irw2, srca2, rw2, rdst2,
                   aluop2, srcb2, pcsrc2, ill2};

   // vector table
   typedef struct packed {
      logic [5:0]  op;
      logic        rdy;
      logic [3:0]  st;
      logic [16:0] ctrl;
      logic [15:0] cnt;
   } vec_t;

   vec_t vecs [0:63];
   int   n_vec  = 0;
   int   checks = 0;
   int   errors = 0;

   task automatic add(input logic [5:0] op, input logic rdy, input logic [3:0] st,
                      input logic [16:0] ctrl, input logic [15:0] cnt);
      vecs[n_vec] = '{op, rdy, st, ctrl, cnt};
      n_vec++;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic adv();
      @(posedge Clk);
      #1;
   endtask

   initial begin
      // main sequence lw, sw, R, beq, j, addi with MemReady=1
      add(OP_BAD, 1'b1, 4'd0, E_FETCH, 16'd0);
      add(OP_LW,  1'b1, 4'd1, E_DEC,   16'd0);
      add(OP_BAD, 1'b1, 4'd2, E_MADR,  16'd0);
      add(OP_BAD, 1'b1, 4'd3, E_MRD,   16'd0);
      add(OP_BAD, 1'b1, 4'd4, E_MWB,   16'd0);
      add(OP_BAD, 1'b1, 4'd0, E_FETCH, 16'd1);
      add(OP_SW,  1'b1, 4'd1, E_DEC,   16'd1);
      add(OP_BAD, 1'b1, 4'd2, E_MADR,  16'd1);
      add(OP_BAD, 1'b1, 4'd5, E_MWR,   16'd1);
      add(OP_BAD, 1'b1, 4'd0, E_FETCH, 16'd2);
      add(OP_R,   1'b1, 4'd1, E_DEC,   16'd2);
      add(OP_BAD, 1'b1, 4'd6, E_EXEC,  16'd2);
      add(OP_BAD, 1'b1, 4'd7, E_RC,    16'd2);
      add(OP_BAD, 1'b1, 4'd0, E_FETCH, 16'd3);
      add(OP_BEQ, 1'b1, 4'd1, E_DEC,   16'd3);
      add(OP_BAD, 1'b1, 4'd8, E_BR,    16'd3);
      add(OP_BAD, 1'b1, 4'd0, E_FETCH, 16'd4);
      add(OP_J,   1'b1, 4'd1, E_DEC,   16'd4);
      add(OP_BAD, 1'b1, 4'd9, E_J,     16'd4);
      add(OP_BAD, 1'b1, 4'd0, E_FETCH, 16'd5);
      add(OP_ADDI,1'b1, 4'd1, E_DEC,   16'd5);
      add(OP_BAD, 1'b1, 4'd10, E_AEX,  16'd5);
      add(OP_BAD, 1'b1, 4'd11, E_AWB,  16'd5);
      // lw with 3 wait cycles in FETCH and 2 in MEMRD (10 cycles)
      add(OP_BAD, 1'b0, 4'd0, E_FETCH_W, 16'd6);
      add(OP_BAD, 1'b0, 4'd0, E_FETCH_W, 16'd6);
      add(OP_BAD, 1'b0, 4'd0, E_FETCH_W, 16'd6);
      add(OP_BAD, 1'b1, 4'd0, E_FETCH,   16'd6);
      add(OP_LW,  1'b0, 4'd1, E_DEC,     16'd6);
      add(OP_BAD, 1'b0, 4'd2, E_MADR,    16'd6);
      add(OP_BAD, 1'b0, 4'd3, E_MRD,     16'd6);
      add(OP_BAD, 1'b0, 4'd3, E_MRD,     16'd6);
      add(OP_BAD, 1'b1, 4'd3, E_MRD,     16'd6);
      add(OP_BAD, 1'b0, 4'd4, E_MWB,     16'd6);
      // illegal opcode: flagged in DECODE, back to FETCH, not counted
      add(OP_BAD, 1'b1, 4'd0, E_FETCH,   16'd7);
      add(OP_BAD, 1'b1, 4'd1, E_DEC_ILL, 16'd7);
      add(OP_BAD, 1'b1, 4'd0, E_FETCH,   16'd7);

      // reset state, outputs forced low even with MemReady high
      Reset = 1'b1; MemReady = 1'b1; Op = OP_R;
      rst2 = 1'b1; rdy2 = 1'b1; op2 = OP_R;
      #1;
      chk("reset state",  32'(st1),   32'd0);
      chk("reset count",  32'(cnt1),  32'd0);
      chk("reset ctrl",   32'(ctrl1), 32'd0);
      chk("reset2 ctrl",  32'(ctrl2), 32'd0);
      adv();
      adv();
      Reset = 1'b0;

      for (int i = 0; i < n_vec; i++) begin
         Op       = vecs[i].op;
         MemReady = vecs[i].rdy;
         #2;
         chk($sformatf("row%0d state", i), 32'(st1),   32'(vecs[i].st));
         chk($sformatf("row%0d ctrl", i),  32'(ctrl1), 32'(vecs[i].ctrl));
         chk($sformatf("row%0d count", i), 32'(cnt1),  32'(vecs[i].cnt));
         adv();
      end

      // now in DECODE: issue lw and reset it during MEMRD
      Op = OP_LW; MemReady = 1'b1;
      #2;
      chk("rst seq decode", 32'(st1), 32'd1);
      adv();
      Op = OP_BAD;
      adv();
      MemReady = 1'b0;
      #2;
      chk("rst seq memrd", 32'(st1), 32'd3);
      Reset = 1'b1;
      #1;
      chk("mid reset state", 32'(st1),   32'd0);
      chk("mid reset count", 32'(cnt1),  32'd0);
      chk("mid reset ctrl",  32'(ctrl1), 32'd0);
      adv();
      chk("held reset ctrl", 32'(ctrl1), 32'd0);
      chk("held reset state", 32'(st1),  32'd0);
      Reset = 1'b0; MemReady = 1'b1;
      #1;
      chk("post reset ctrl",  32'(ctrl1), 32'(E_FETCH));
      chk("post reset state", 32'(st1),   32'd0);
      adv();
      #1;
      chk("post reset decode", 32'(st1), 32'd1);
      chk("post reset count",  32'(cnt1), 32'd0);

      // instance 2: addi is illegal, MemReady ignored
      rst2 = 1'b0; rdy2 = 1'b0; op2 = OP_BAD;
      #2;
      chk("d2 fetch state", 32'(st2),   32'd0);
      chk("d2 fetch ctrl",  32'(ctrl2), 32'(E_FETCH));
      adv();
      op2 = OP_ADDI;
      #2;
      chk("d2 addi state", 32'(st2),   32'd1);
      chk("d2 addi ctrl",  32'(ctrl2), 32'(E_DEC_ILL));
      adv();
      op2 = OP_BAD;
      #2;
      chk("d2 addi next", 32'(st2),  32'd0);
      chk("d2 addi cnt",  32'(cnt2), 32'd0);

      // 17 jumps on a 4-bit counter: 15, then 0, then 1
      for (int k = 1; k <= 17; k++) begin
         adv();
         op2 = OP_J;
         #2;
         chk($sformatf("d2 j%0d decode", k), 32'(ctrl2), 32'(E_DEC));
         adv();
         op2 = OP_BAD;
         #2;
         chk($sformatf("d2 j%0d jump", k), 32'(st2), 32'd9);
         adv();
         #2;
         chk($sformatf("d2 j%0d cnt", k), 32'(cnt2), 32'(k % 16));
      end

      // sw with MemReady held low finishes in 4 cycles, MemWrite for one
      rdy2 = 1'b0; op2 = OP_BAD;
      chk("d2 sw fetch ctrl", 32'(ctrl2), 32'(E_FETCH));
      adv();
      op2 = OP_SW;
      #2;
      chk("d2 sw decode", 32'(ctrl2), 32'(E_DEC));
      adv();
      op2 = OP_BAD;
      #2;
      chk("d2 sw memadr", 32'(st2),   32'd2);
      chk("d2 sw memadr ctrl", 32'(ctrl2), 32'(E_MADR));
      adv();
      #2;
      chk("d2 sw memwr", 32'(st2),   32'd5);
      chk("d2 sw memwr ctrl", 32'(ctrl2), 32'(E_MWR));
      adv();
      #2;
      chk("d2 sw done state", 32'(st2),  32'd0);
      chk("d2 sw done mw",    32'(mw2),  32'd0);
      chk("d2 sw done cnt",   32'(cnt2), 32'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle main control unit for the MIPS datapath: a Moore state machine that sequences each instruction over 3–5+ cycles through fetch, decode, execute, memory and writeback. It drives the shared-memory/single-ALU datapath (PC, IR, A/B/ALUOut/MDR registers). Over the single-cycle decoder it adds:
- a memory ready handshake with wait states;
- optional addi support;
- illegal-opcode detection;
- a retired-instruction counter.

## Interface
Parameters:
- CNT_W, 16, width of InstrCount
- HAS_ADDI, 1, 1 = opcode 001000 (addi) is legal; 0 = it is illegal
- MEM_HANDSHAKE, 1, 1 = memory states wait for MemReady; 0 = MemReady ignored, treated as 1

Ports (one clock; reset is asynchronous and active-high):
- Clk  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- Op  in  6  opcode from IR[31:26], sampled only in DECODE
- MemReady  in  1  memory access completes this cycle
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  out  1 each  datapath controls
- ALUOp  out  2  00 add, 01 subtract, 10 use funct
- ALUSrcB  out  2  00 B, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target
- IllegalOp  out  1  unsupported opcode detected in DECODE
- State  out  4  current state encoding (debug)
- InstrCount  out  CNT_W  retired-instruction count

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000 (only when HAS_ADDI=1).
- Any output not listed for a state is 0.
- Per-state outputs and transitions (state number = State encoding):
  - 0 FETCH: MemRead=1, ALUSrcB=01, IRWrite=PCWrite=MemReady. Holds until MemReady, then goes to DECODE.
  - 1 DECODE: ALUSrcB=11. Next state by Op: lw/sw→2, R→6, beq→8, j→9, addi→10, other→0.
  - 2 MEMADR: ALUSrcA=1, ALUSrcB=10. lw→3, sw→5.
  - 3 MEMRD: MemRead=1, IorD=1. Holds until MemReady, then →4.
  - 4 MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. →0.
  - 5 MEMWR: MemWrite=1, IorD=1. Holds until MemReady, then →0.
  - 6 EXEC: ALUSrcA=1, ALUOp=10. →7.
  - 7 RCOMP: RegWrite=1, RegDst=1. →0.
  - 8 BRANCH: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01. →0.
  - 9 JUMP: PCWrite=1, PCSource=10. →0.
  - 10 ADDIEX: ALUSrcA=1, ALUSrcB=10. →11.
  - 11 ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0. →0.
  - Encodings 12–15 are unreachable; if entered, go to 0 with all outputs 0.
- IllegalOp is combinational. It is 1 only in DECODE when Op is unsupported. The FSM then returns to FETCH and the instruction is not counted.
- InstrCount:
  - Increments by 1 on the edge leaving a final state: MEMWB, MEMWR (with MemReady), RCOMP, BRANCH, JUMP, ADDIWB.
  - Wraps from 2^CNT_W−1 to 0.
  - Not incremented on illegal opcodes.

## Timing
- Reset asserted: State=0 and InstrCount=0 immediately (asynchronous); all control outputs and IllegalOp are forced to 0 while Reset is high.
- First FETCH cycle is the first rising edge after Reset deasserts.
- Reset mid-instruction aborts it: no count, no further writes.
- Minimum latency with MemReady=1: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3. Each cycle MemReady=0 in FETCH/MEMRD/MEMWR adds one cycle.
- Handshake: a memory state stays active, with outputs stable, until MemReady=1. Completion occurs in the cycle MemReady=1 is seen.
- Outputs are Moore (state-only), except IRWrite/PCWrite in FETCH and IllegalOp. No output depends on Op outside DECODE.
- MEM_HANDSHAKE=0: every memory state lasts exactly 1 cycle regardless of MemReady.

## Test plan
- Reset during MEMRD of an lw → State=0, InstrCount=0, all controls 0; after release, FETCH outputs MemRead=1, ALUSrcB=01.
- MemReady=1, sequence lw, sw, R, beq, j, addi → state traces 0,1,2,3,4 / 0,1,2,5 / 0,1,6,7 / 0,1,8 / 0,1,9 / 0,1,10,11; InstrCount=6 after 23 cycles.
- lw with MemReady low for 3 cycles in FETCH and 2 in MEMRD → 10 cycles total; IRWrite pulses once, RegWrite pulses once in MEMWB.
- Op=111111 in DECODE → IllegalOp=1 for that cycle, next State=0, InstrCount unchanged; HAS_ADDI=0 with Op=001000 → same response.
- CNT_W=4, 17 j instructions → InstrCount reaches 15, then wraps to 0, then reads 1.
- MEM_HANDSHAKE=0, MemReady held 0, sw → completes in 4 cycles with MemWrite=1 for 1 cycle.
